calc_req_driver: RTL and testbench
==================================

# calc_req_driver

Request driver placed directly upstream of one calc1 request port. It accepts whole operations (command plus both operands) on a valid/ready interface and buffers them in a small FIFO. It serialises each operation onto the two-cycle calc1 port protocol, waits for the matching response with a timeout, and returns the result on a valid/ready result interface. One instance is used per calc1 port (four per calc1_top).

## Interface
- DEPTH, 4: request FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 64: number of WAIT cycles without a response before the driver reports a timeout; range 1..255.

- c_clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous and active-low (one clock; reset asynchronous active-low).
- in_valid  in  1  operation offered.
- in_ready  out  1  equals !fifo_full.
- in_cmd  in  4  operation code: 1 add, 2 sub, 5 shl, 6 shr. Any other nonzero value passes through unchanged.
- in_op1  in  32  operand 1.
- in_op2  in  32  operand 2.
- req_cmd_out  out  4  drives the calc1 reqN_cmd_in port.
- req_data_out  out  32  drives the calc1 reqN_data_in port.
- resp_in  in  2  from calc1 out_respN: 0 none, 1 ok, 2 overflow/invalid, 3 internal error.
- resp_data_in  in  32  from calc1 out_dataN.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer accepts.
- res_resp  out  2  captured response code.
- res_data  out  32  captured result data.
- res_timeout  out  1  set when the result is a timeout.
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- stray_cnt  out  8  saturating count of nonzero resp_in samples taken outside WAIT.

## Operation
- FIFO:
  - A push occurs on in_valid && in_ready.
  - An operation with in_cmd==0 is accepted (handshake completes) but is not enqueued.
  - in_ready does not account for a same-cycle pop. When the FIFO is full, a push is refused even in a cycle where a pop occurs.
  - Read and write pointers wrap modulo DEPTH. A full/empty flag or an extra pointer bit distinguishes full from empty.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop into the op register and go to SEND1.
  - SEND1: req_cmd_out=cmd, req_data_out=op1. Go to SEND2.
  - SEND2: req_cmd_out=0, req_data_out=op2. Clear the timeout counter. Go to WAIT.
  - WAIT: req_cmd_out=0, req_data_out=0. Increment the timeout counter each cycle.
    - If resp_in!=0: capture res_resp=resp_in and res_data=resp_data_in, set res_timeout=0, go to HOLD.
    - Otherwise, when the counter reaches TIMEOUT_CYCLES: set res_resp=0, res_data=0, res_timeout=1, go to HOLD.
    - If a response and the timeout occur in the same cycle, the response wins.
  - HOLD: res_valid=1 and all result fields are held stable. On res_ready, go to IDLE. The pop of the next operation happens in IDLE, so there is one bubble cycle.
- Outside SEND1 and SEND2, req_cmd_out and req_data_out are 0.
- A nonzero resp_in in any state other than WAIT is ignored and increments stray_cnt. stray_cnt saturates at 255.
- Reset (asynchronous):
  - FIFO is emptied.
  - FSM goes to IDLE, the timeout counter is cleared, and stray_cnt is cleared.
  - res_valid, res_resp, res_data, res_timeout, req_cmd_out, req_data_out and busy are all 0.
  - in_ready reads 1.
  - An operation in flight is discarded without a result. A calc1 response that arrives after reset release counts as stray.

## Timing
- Push at edge T with an empty FIFO in IDLE:
  - T+1: IDLE pops.
  - T+2: SEND1 (cmd and op1 on the port).
  - T+3: SEND2 (op2 on the port).
  - T+4 onward: WAIT.
- If resp_in is first nonzero in WAIT cycle W, res_valid is high from W+1.
- Timeout: res_valid is high exactly TIMEOUT_CYCLES+1 cycles after the first WAIT cycle.
- Back-to-back operations: HOLD handshake at edge H, IDLE at H+1, SEND1 at H+2.
- All outputs are registered except in_ready, which is combinational from FIFO state.

## Test plan
- Add: push cmd=1, op1=5, op2=3. Model responds with resp=1, data=8 two cycles into WAIT. Expect:
  - port sequence (1,5), (0,3);
  - res_valid with res_resp=1, res_data=8, res_timeout=0.
- Backpressure and full FIFO: keep res_ready=0 and push 5 adds while the model never responds. Expect:
  - 4 entries accepted plus 1 held in the op register, so the 5th push completes;
  - a 6th push sees in_ready=0;
  - in_ready=1 returns one cycle after the first pop.
- Timeout: push cmd=2, op1=10, op2=4 and never respond. Expect res_valid with res_timeout=1, res_resp=0, res_data=0, exactly 65 cycles after the first WAIT cycle. Then release res_ready and confirm the FSM returns to IDLE.
- Response/timeout collision: set TIMEOUT_CYCLES=8 and respond resp=2, data=0 on the 8th WAIT cycle. Expect res_resp=2 and res_timeout=0.
- Stray response and nop: drive resp_in=1 while in IDLE on 3 cycles, and push cmd=0. Expect:
  - stray_cnt=3;
  - the nop is accepted with no port activity and busy stays 0.
- Reset mid-operation: assert reset asynchronously during WAIT. Expect:
  - all outputs 0 immediately, in_ready=1;
  - after release, a late resp=1 increments stray_cnt to 1 and produces no res_valid.

Source files
------------

// File: rtl/calc_req_driver.sv
// Request driver for one calc1 port: buffers whole operations in a small FIFO,
// serialises each onto the two-cycle port protocol and returns the response or a timeout.
module calc_req_driver #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cmd,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  output logic [3:0]  req_cmd_out,
  output logic [31:0] req_data_out,
  input  logic [1:0]  resp_in,
  input  logic [31:0] resp_data_in,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [1:0]  res_resp,
  output logic [31:0] res_data,
  output logic        res_timeout,
  output logic        busy,
  output logic [7:0]  stray_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {ST_IDLE, ST_SEND1, ST_SEND2, ST_WAIT, ST_HOLD} state_t;

  state_t      state;
  logic [67:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
  logic        fifo_empty, fifo_full, push, pop;
  logic        state_busy_nx, busy_nx;
  logic [31:0] op2_reg;
  logic [7:0]  tmo_cnt;

  // The extra pointer bit separates the full and empty cases.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready && (in_cmd != 4'd0);
  assign pop        = (state == ST_IDLE) && !fifo_empty;
  assign wr_ptr_nx  = wr_ptr + (AW+1)'(push);
  assign rd_ptr_nx  = rd_ptr + (AW+1)'(pop);

  always_comb begin
    state_busy_nx = 1'b1;
    if (state == ST_IDLE)
      state_busy_nx = pop;
    else if (state == ST_HOLD)
      state_busy_nx = !res_ready;
    busy_nx = state_busy_nx || (wr_ptr_nx != rd_ptr_nx);
  end

  always_ff @(posedge c_clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {in_cmd, in_op1, in_op2};
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_nx;
      rd_ptr <= rd_ptr_nx;
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      op2_reg      <= '0;
      tmo_cnt      <= '0;
      stray_cnt    <= '0;
      req_cmd_out  <= '0;
      req_data_out <= '0;
      res_valid    <= 1'b0;
      res_resp     <= '0;
      res_data     <= '0;
      res_timeout  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      busy <= busy_nx;
      if ((state != ST_WAIT) && (resp_in != 2'd0) && (stray_cnt != 8'hFF))
        stray_cnt <= stray_cnt + 8'd1;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            // Port outputs are loaded on entry so they line up with SEND1.
            req_cmd_out  <= mem[rd_ptr[AW-1:0]][67:64];
            req_data_out <= mem[rd_ptr[AW-1:0]][63:32];
            op2_reg      <= mem[rd_ptr[AW-1:0]][31:0];
            state        <= ST_SEND1;
          end
        end
        ST_SEND1: begin
          req_cmd_out  <= 4'd0;
          req_data_out <= op2_reg;
          state        <= ST_SEND2;
        end
        ST_SEND2: begin
          req_data_out <= '0;
          tmo_cnt      <= '0;
          state        <= ST_WAIT;
        end
        ST_WAIT: begin
          if (resp_in != 2'd0) begin
            res_resp    <= resp_in;
            res_data    <= resp_data_in;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            state       <= ST_HOLD;
          end else if (tmo_cnt == 8'(TIMEOUT_CYCLES)) begin
            res_resp    <= '0;
            res_data    <= '0;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            state       <= ST_HOLD;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_req_driver.sv
// Directed bench for calc_req_driver: add, full FIFO, timeout, collision, stray/nop, reset.
module tb_calc_req_driver;

  logic        c_clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_cmd;
  logic [31:0] in_op1, in_op2;
  logic [1:0]  resp_in;
  logic [31:0] resp_data_in;
  logic        res_ready;

  logic        in_ready, res_valid, res_timeout, busy;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out, res_data;
  logic [1:0]  res_resp;
  logic [7:0]  stray_cnt;

  logic        in_ready8, res_valid8, res_timeout8, busy8;
  logic [3:0]  req_cmd8;
  logic [31:0] req_data8, res_data8;
  logic [1:0]  res_resp8;
  logic [7:0]  stray8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 c_clk = ~c_clk;

  calc_req_driver #(.DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
    .c_clk(c_clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_op1(in_op1), .in_op2(in_op2),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
    .resp_in(resp_in), .resp_data_in(resp_data_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_resp(res_resp),
    .res_data(res_data), .res_timeout(res_timeout), .busy(busy), .stray_cnt(stray_cnt)
  );

  calc_req_driver #(.DEPTH(4), .TIMEOUT_CYCLES(8)) dut8 (
    .c_clk(c_clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
    .in_cmd(in_cmd), .in_op1(in_op1), .in_op2(in_op2),
    .req_cmd_out(req_cmd8), .req_data_out(req_data8),
    .resp_in(resp_in), .resp_data_in(resp_data_in),
    .res_valid(res_valid8), .res_ready(res_ready), .res_resp(res_resp8),
    .res_data(res_data8), .res_timeout(res_timeout8), .busy(busy8), .stray_cnt(stray8)
  );

  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({req_cmd_out, req_data_out, res_valid, res_resp, res_data, res_timeout, busy, stray_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got cmd=%0h data=%0h vld=%0b resp=%0d rdata=%0h to=%0b busy=%0b stray=%0d, need all 0",
               req_cmd_out, req_data_out, res_valid, res_resp, res_data, res_timeout, busy, stray_cnt);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b need 1", in_ready); end
    reset = 1'b1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_add();
    in_valid = 1'b1; in_cmd = 4'd1; in_op1 = 32'd5; in_op2 = 32'd3; res_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL add_busy: got %0b need 1", busy); end
    step();
    n_cmp++;
    if (req_cmd_out !== 4'd1 || req_data_out !== 32'd5) begin
      n_err++; $display("FAIL add_send1: got (%0d,%0d) need (1,5)", req_cmd_out, req_data_out);
    end
    step();
    n_cmp++;
    if (req_cmd_out !== 4'd0 || req_data_out !== 32'd3) begin
      n_err++; $display("FAIL add_send2: got (%0d,%0d) need (0,3)", req_cmd_out, req_data_out);
    end
    step();
    n_cmp++;
    if (req_cmd_out !== 4'd0 || req_data_out !== 32'd0) begin
      n_err++; $display("FAIL add_wait_port: got (%0d,%0d) need (0,0)", req_cmd_out, req_data_out);
    end
    step();
    step();
    resp_in = 2'd1; resp_data_in = 32'd8;
    n_cmp++;
    if (res_valid !== 1'b0) begin n_err++; $display("FAIL add_early_valid: got %0b need 0", res_valid); end
    step();
    resp_in = 2'd0; resp_data_in = 32'd0;
    n_cmp++;
    if (res_valid !== 1'b1 || res_resp !== 2'd1 || res_data !== 32'd8 || res_timeout !== 1'b0) begin
      n_err++; $display("FAIL add_result: got vld=%0b resp=%0d data=%0d to=%0b need 1/1/8/0",
                        res_valid, res_resp, res_data, res_timeout);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL add_release: got vld=%0b busy=%0b need 0/0", res_valid, busy);
    end
    $display("test_add done");
  endtask

  task automatic test_timeout();
    int k;
    in_valid = 1'b1; in_cmd = 4'd2; in_op1 = 32'd10; in_op2 = 32'd4; res_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (req_cmd_out !== 4'd2 || req_data_out !== 32'd10) begin
      n_err++; $display("FAIL tmo_send1: got (%0d,%0d) need (2,10)", req_cmd_out, req_data_out);
    end
    step();
    n_cmp++;
    if (req_cmd_out !== 4'd0 || req_data_out !== 32'd4) begin
      n_err++; $display("FAIL tmo_send2: got (%0d,%0d) need (0,4)", req_cmd_out, req_data_out);
    end
    step();
    k = 0;
    while (res_valid !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    n_cmp++;
    if (k !== 65) begin n_err++; $display("FAIL tmo_latency: got %0d cycles need 65", k); end
    n_cmp++;
    if (res_valid !== 1'b1 || res_timeout !== 1'b1 || res_resp !== 2'd0 || res_data !== 32'd0) begin
      n_err++; $display("FAIL tmo_result: got vld=%0b to=%0b resp=%0d data=%0d need 1/1/0/0",
                        res_valid, res_timeout, res_resp, res_data);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL tmo_idle: got vld=%0b busy=%0b need 0/0", res_valid, busy);
    end
    $display("test_timeout done: latency %0d", k);
  endtask

  task automatic test_collision();
    do_reset();
    in_valid = 1'b1; in_cmd = 4'd1; in_op1 = 32'd7; in_op2 = 32'd9; res_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    // Now in the first WAIT cycle; the 8-cycle instance decides timeout 8 cycles later.
    for (int i = 0; i < 8; i++) step();
    resp_in = 2'd2; resp_data_in = 32'd0;
    n_cmp++;
    if (res_valid8 !== 1'b0) begin n_err++; $display("FAIL coll_early_valid: got %0b need 0", res_valid8); end
    step();
    resp_in = 2'd0;
    n_cmp++;
    if (res_valid8 !== 1'b1 || res_resp8 !== 2'd2 || res_timeout8 !== 1'b0 || res_data8 !== 32'd0) begin
      n_err++; $display("FAIL coll_result: got vld=%0b resp=%0d to=%0b data=%0d need 1/2/0/0",
                        res_valid8, res_resp8, res_timeout8, res_data8);
    end
    $display("test_collision done");
  endtask

  task automatic test_stray_nop();
    do_reset();
    resp_in = 2'd1;
    step();
    step();
    step();
    resp_in = 2'd0;
    n_cmp++;
    if (stray_cnt !== 8'd3) begin n_err++; $display("FAIL stray_count: got %0d need 3", stray_cnt); end
    in_valid = 1'b1; in_cmd = 4'd0; in_op1 = 32'd11; in_op2 = 32'd12;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL nop_ready: got %0b need 1", in_ready); end
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (req_cmd_out !== 4'd0 || req_data_out !== 32'd0 || busy !== 1'b0) begin
        n_err++; $display("FAIL nop_quiet[%0d]: got cmd=%0d data=%0d busy=%0b need 0/0/0",
                          i, req_cmd_out, req_data_out, busy);
      end
      step();
    end
    $display("test_stray_nop done");
  endtask

  task automatic test_full();
    int k;
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_cmd = 4'd1; in_op1 = 32'(i); in_op2 = 32'(i);
      n_cmp++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_push[%0d]: got in_ready=%0b need 1", i, in_ready); end
      step();
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_sixth: got in_ready=%0b need 0", in_ready); end
    in_valid = 1'b0;
    k = 0;
    while (res_valid !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    n_cmp++;
    if (res_valid !== 1'b1 || res_timeout !== 1'b1) begin
      n_err++; $display("FAIL full_first_result: got vld=%0b to=%0b need 1/1", res_valid, res_timeout);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_before_pop: got in_ready=%0b need 0", in_ready); end
    step();
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_after_pop: got in_ready=%0b need 1", in_ready); end
    $display("test_full done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1; in_cmd = 4'd1; in_op1 = 32'd5; in_op2 = 32'd3; res_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({req_cmd_out, req_data_out, res_valid, res_resp, res_data, res_timeout, busy, stray_cnt} !== '0) begin
      n_err++; $display("FAIL async_reset_outputs: got cmd=%0h data=%0h vld=%0b busy=%0b stray=%0d need all 0",
                        req_cmd_out, req_data_out, res_valid, busy, stray_cnt);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL async_reset_ready: got %0b need 1", in_ready); end
    step();
    reset = 1'b1;
    resp_in = 2'd1; resp_data_in = 32'd8;
    step();
    resp_in = 2'd0; resp_data_in = 32'd0;
    n_cmp++;
    if (stray_cnt !== 8'd1) begin n_err++; $display("FAIL late_resp_stray: got %0d need 1", stray_cnt); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (res_valid !== 1'b0) begin n_err++; $display("FAIL late_resp_valid[%0d]: got %0b need 0", i, res_valid); end
      step();
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_cmd = '0; in_op1 = '0; in_op2 = '0;
    resp_in = '0; resp_data_in = '0; res_ready = 1'b0;
    step();
    step();
    test_reset();
    test_add();
    test_timeout();
    test_collision();
    test_stray_nop();
    test_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
